mod_mult_operand_stage: RTL and testbench
=========================================

Name: mod_mult_operand_stage

Overview:
- Upstream feeder for the modulo reducer in the ElGamal datapath.
- Accepts two SIZE-bit operands and a SIZE-bit modulus on AXI-stream style inputs.
- Computes the full 2*SIZE-bit product with a radix-2 shift-add multiplier.
- Presents the product as the reducer's dividend stream and forwards the modulus as the reducer's divisor stream. Together with the reducer this forms one modular multiply for the exponentiation loop.

Parameters:
SIZE, 64, operand and modulus width; product width is 2*SIZE.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
op_a_tdata  in  SIZE  multiplicand
op_a_tvalid  in  1  multiplicand valid
op_a_tready  out  1  multiplicand ready
op_b_tdata  in  SIZE  multiplier
op_b_tvalid  in  1  multiplier valid
op_b_tready  out  1  multiplier ready
modulus_tdata  in  SIZE  modulus
modulus_tvalid  in  1  modulus valid
modulus_tready  out  1  modulus ready
product_tdata  out  2*SIZE  a*b, to reducer dividend input
product_tvalid  out  1  product valid
product_tready  in  1  reducer dividend ready
divisor_tdata  out  SIZE  latched modulus, to reducer divisor input
divisor_tvalid  out  1  divisor valid
divisor_tready  in  1  reducer divisor ready

Behaviour:
- Clock and reset: one clock; rst is asynchronous and active-low.
- Reset (rst low, any time, including mid-multiply or mid-output):
  - state=IDLE; accumulator, shifted multiplicand, multiplier register, modulus register and bit counter cleared.
  - product_tvalid=0, divisor_tvalid=0, all three input treadys=0 while rst is low.
  - Any in-flight operation is discarded with no output.
- FSM states: IDLE, MULT, OUT.
- IDLE:
  - op_a_tready, op_b_tready and modulus_tready all equal (state==IDLE); they do not depend on any tvalid.
  - Accept only on an edge where all three tvalids are high; all three streams handshake on that same edge.
  - Partial valid (e.g. a and b high, modulus low): nothing is consumed, stay IDLE.
  - On accept, latch:
    - acc=0
    - mcand={SIZE zeros, op_a}
    - mplier=op_b
    - mod_r=modulus
    - cnt=0
    - next state MULT.
- MULT, one bit per cycle, exactly SIZE cycles:
  - If mplier[0], then acc <= acc + mcand, mod 2^(2*SIZE); no overflow is possible.
  - mcand <<= 1, mplier >>= 1, cnt++.
  - On the edge where cnt==SIZE-1: go to OUT and set product_tvalid=1 and divisor_tvalid=1 on that same edge.
  - Latency: both tvalids rise SIZE clock edges after the accepting edge.
  - No early termination when the multiplier is zero; latency is fixed.
- OUT:
  - product_tdata=acc and divisor_tdata=mod_r, both held stable while the corresponding tvalid is high.
  - Each output stream completes independently: its tvalid drops on the edge where tvalid&tready.
  - The two streams may complete on the same edge or on different edges, in either order.
  - A tvalid, once high, never drops without its handshake.
  - On the edge where the last outstanding stream completes, go to IDLE; input treadys are high from the next cycle.
  - If both treadys are already high on entry to OUT, the output occupies exactly one cycle.
- Modulus is passed through unchecked; modulus zero is forwarded unchanged and handled by the reducer.
- Throughput: at most one operation per SIZE+2 cycles (accept, SIZE MULT cycles, at least one OUT cycle).

Test Plan:
1. SIZE=64, a=3, b=5, mod=7, all valid, downstream treadys tied high.
   -> Inputs accepted on one edge; 64 edges later product=15 and divisor=7 with both tvalids high for exactly one cycle; treadys high again on the following cycle.
2. SIZE=64, a=b=0xFFFFFFFFFFFFFFFF, mod=0xFFFFFFFFFFFFFFC5.
   -> product=0xFFFFFFFFFFFFFFFE0000000000000001, divisor=0xFFFFFFFFFFFFFFC5.
3. a=0, b=0x1234, mod=11.
   -> product=0 after the full 64-cycle latency; no early completion.
4. Staggered inputs: a and b valid at cycle 0, modulus valid at cycle 4.
   -> No ready/valid handshake before cycle 4; all three streams consumed together at cycle 4; product ready at cycle 68.
5. Backpressure: divisor_tready=1, product_tready held low for 5 cycles after valid.
   -> divisor_tvalid drops after 1 cycle; product_tvalid and product_tdata held stable for 5 cycles; input treadys stay low until the cycle after the product handshake; a new set of inputs offered meanwhile is not consumed early.
6. rst driven low asynchronously mid-MULT (cnt=30) and again mid-OUT.
   -> All tvalids and treadys low immediately with no clock edge required; after release the block is IDLE; a subsequent 3*5 mod 7 operation produces 15/7 with normal latency.

Source files
------------

// File: rtl/mod_mult_operand_stage_if.sv
// Ready/valid stream bundle used for the operand, modulus, product and divisor
// ports of the modular-multiply operand stage.
interface mod_mult_operand_stage_if #(
    parameter int W = 64
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mod_mult_operand_stage.sv
// Radix-2 shift-add multiplier that feeds a*b and the latched modulus to the
// downstream modulo reducer as its dividend and divisor streams.
module mod_mult_operand_stage #(
    parameter int SIZE = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    mod_mult_operand_stage_if.slave         op_a,
    mod_mult_operand_stage_if.slave         op_b,
    mod_mult_operand_stage_if.slave         modulus,
    mod_mult_operand_stage_if.master        product,
    mod_mult_operand_stage_if.master        divisor
);
    localparam int CNT_W = $clog2(SIZE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [2*SIZE-1:0]   acc_q,    acc_d;
    logic [2*SIZE-1:0]   mcand_q,  mcand_d;
    logic [SIZE-1:0]     mplier_q, mplier_d;
    logic [SIZE-1:0]     mod_q,    mod_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                pvalid_q, pvalid_d;
    logic                dvalid_q, dvalid_d;
    logic                accept_s;
    logic                in_ready_s;

    // Readies must fall the instant rst is asserted, not at the next edge.
    assign in_ready_s = (state_q == ST_IDLE) && rst;
    assign accept_s   = (state_q == ST_IDLE) && op_a.tvalid && op_b.tvalid && modulus.tvalid;

    assign op_a.tready    = in_ready_s;
    assign op_b.tready    = in_ready_s;
    assign modulus.tready = in_ready_s;
    assign product.tdata  = acc_q;
    assign product.tvalid = pvalid_q;
    assign divisor.tdata  = mod_q;
    assign divisor.tvalid = dvalid_q;

    // Next-state and datapath update for the accept / multiply / output sequence.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mod_d    = mod_q;
        cnt_d    = cnt_q;
        pvalid_d = pvalid_q;
        dvalid_d = dvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    acc_d    = '0;
                    mcand_d  = {{SIZE{1'b0}}, op_a.tdata};
                    mplier_d = op_b.tdata;
                    mod_d    = modulus.tdata;
                    cnt_d    = '0;
                    state_d  = ST_MULT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[2*SIZE-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[SIZE-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                // Fixed latency: no early exit even when the multiplier runs out of ones.
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_OUT;
                    pvalid_d = 1'b1;
                    dvalid_d = 1'b1;
                end else begin
                    state_d  = ST_MULT;
                end
            end
            ST_OUT: begin
                pvalid_d = pvalid_q && !product.tready;
                dvalid_d = dvalid_q && !divisor.tready;
                if (!pvalid_d && !dvalid_d) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pvalid_d = 1'b0;
                dvalid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            mod_q    <= '0;
            cnt_q    <= '0;
            pvalid_q <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mod_q    <= mod_d;
            cnt_q    <= cnt_d;
            pvalid_q <= pvalid_d;
            dvalid_q <= dvalid_d;
        end
    end
endmodule

// File: tb/tb_mod_mult_operand_stage.sv
// Self-checking bench for mod_mult_operand_stage: directed vector table,
// hand-written handshake/reset sequences and randomized operations.
module tb_mod_mult_operand_stage;
    localparam int SIZE = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mod_mult_operand_stage_if #(.W(SIZE))   op_a_if ();
    mod_mult_operand_stage_if #(.W(SIZE))   op_b_if ();
    mod_mult_operand_stage_if #(.W(SIZE))   mod_if ();
    mod_mult_operand_stage_if #(.W(2*SIZE)) prod_if ();
    mod_mult_operand_stage_if #(.W(SIZE))   div_if ();

    mod_mult_operand_stage #(.SIZE(SIZE)) dut (
        .clk     (clk),
        .rst     (rst),
        .op_a    (op_a_if),
        .op_b    (op_b_if),
        .modulus (mod_if),
        .product (prod_if),
        .divisor (div_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        logic [SIZE-1:0]   m;
        int                p_hold;
        int                d_hold;
        logic [2*SIZE-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [2*SIZE-1:0] ref_product(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [2*SIZE-1:0] wa;
        logic [2*SIZE-1:0] wb;
        wa = {{SIZE{1'b0}}, a};
        wb = {{SIZE{1'b0}}, b};
        return wa * wb;
    endfunction

    task automatic check(input string name, input logic [2*SIZE-1:0] act, input logic [2*SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_pvalid"}, 128'(prod_if.tvalid), 128'd0);
        check({name, "_dvalid"}, 128'(div_if.tvalid), 128'd0);
        check({name, "_ready"}, 128'({op_a_if.tready, op_b_if.tready, mod_if.tready}), 128'd0);
    endtask

    task automatic drive_inputs(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic [SIZE-1:0] m);
        op_a_if.tdata  = a;
        op_b_if.tdata  = b;
        mod_if.tdata   = m;
        op_a_if.tvalid = 1'b1;
        op_b_if.tvalid = 1'b1;
        mod_if.tvalid  = 1'b1;
    endtask

    // Offer a full operand set and return #1 after the accepting edge.
    task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic [SIZE-1:0] m);
        int n;
        n = 0;
        drive_inputs(a, b, m);
        while (!op_a_if.tready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("accept_timeout", 128'd0, 128'd1);
        check("ready_agree", 128'({op_b_if.tready, mod_if.tready}), 128'd3);
        @(posedge clk); #1;
        op_a_if.tvalid = 1'b0;
        op_b_if.tvalid = 1'b0;
        mod_if.tvalid  = 1'b0;
    endtask

    task automatic wait_valid();
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!prod_if.tvalid && lat < 200);
        check("latency", 128'(lat), 128'(SIZE));
        check("divisor_valid_rise", 128'(div_if.tvalid), 128'd1);
    endtask

    task automatic out_phase(input logic [2*SIZE-1:0] exp_p, input logic [SIZE-1:0] exp_m,
                             input int p_hold, input int d_hold, input bit offer);
        bit p_pend;
        bit d_pend;
        int cyc;
        p_pend = 1'b1;
        d_pend = 1'b1;
        cyc    = 0;
        if (offer) drive_inputs(64'd3, 64'd5, 64'd7);
        while ((p_pend || d_pend) && cyc < 50) begin
            check("pvalid", 128'(prod_if.tvalid), 128'(p_pend));
            check("dvalid", 128'(div_if.tvalid), 128'(d_pend));
            if (p_pend) check("product", prod_if.tdata, exp_p);
            if (d_pend) check("divisor", 128'(div_if.tdata), 128'(exp_m));
            check("in_ready_busy", 128'(op_a_if.tready), 128'd0);
            prod_if.tready = (cyc >= p_hold);
            div_if.tready  = (cyc >= d_hold);
            @(posedge clk); #1;
            if (prod_if.tready) p_pend = 1'b0;
            if (div_if.tready)  d_pend = 1'b0;
            cyc++;
        end
        prod_if.tready = 1'b0;
        div_if.tready  = 1'b0;
        check("out_cycles", 128'(cyc), 128'(((p_hold > d_hold) ? p_hold : d_hold) + 1));
        check("done_pvalid", 128'(prod_if.tvalid), 128'd0);
        check("done_dvalid", 128'(div_if.tvalid), 128'd0);
        check("in_ready_after", 128'(op_a_if.tready), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'd3, 64'd5, 64'd7, 0, 0, 128'd15};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFC5, 0, 0,
                    128'hFFFFFFFFFFFFFFFE0000000000000001};
        vecs[2] = '{64'd0, 64'h1234, 64'd11, 0, 0, 128'd0};
        vecs[3] = '{64'd5, 64'd6, 64'd0, 1, 1, 128'd30};
        vecs[4] = '{64'd7, 64'd9, 64'd13, 0, 3, 128'd63};
        vecs[5] = '{64'h8000000000000000, 64'd2, 64'd3, 2, 0, 128'h10000000000000000};

        op_a_if.tvalid = 1'b0; op_b_if.tvalid = 1'b0; mod_if.tvalid = 1'b0;
        op_a_if.tdata = '0; op_b_if.tdata = '0; mod_if.tdata = '0;
        prod_if.tready = 1'b0; div_if.tready = 1'b0;

        #2;
        check_quiet("reset");
        check("reset_product", prod_if.tdata, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_out_of_reset", 128'(op_a_if.tready), 128'd1);

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].m);
            wait_valid();
            out_phase(vecs[i].exp, vecs[i].m, vecs[i].p_hold, vecs[i].d_hold, 1'b0);
        end

        // Staggered: modulus arrives 4 cycles after a and b.
        drive_inputs(64'd11, 64'd12, 64'd13);
        mod_if.tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("stagger_not_consumed", 128'(op_a_if.tready), 128'd1);
        end
        start_op(64'd11, 64'd12, 64'd13);
        wait_valid();
        out_phase(128'd132, 64'd13, 0, 0, 1'b0);

        // Product backpressure with the next operands already waiting.
        start_op(64'h10, 64'h20, 64'h99);
        wait_valid();
        out_phase(128'h200, 64'h99, 5, 0, 1'b1);
        start_op(64'd3, 64'd5, 64'd7);
        wait_valid();
        out_phase(128'd15, 64'd7, 0, 0, 1'b0);

        // Asynchronous reset mid-multiply.
        start_op(64'd9, 64'd9, 64'd5);
        repeat (30) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_quiet("rst_mult");
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_mult_idle", 128'(op_a_if.tready), 128'd1);
        start_op(64'd3, 64'd5, 64'd7);
        wait_valid();
        out_phase(128'd15, 64'd7, 0, 0, 1'b0);

        // Asynchronous reset while the outputs are presented.
        start_op(64'd4, 64'd4, 64'd9);
        wait_valid();
        #2 rst = 1'b0;
        #1 check_quiet("rst_out");
        check("rst_out_divisor", 128'(div_if.tdata), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_out_idle", 128'(op_a_if.tready), 128'd1);
        check("rst_out_no_valid", 128'(prod_if.tvalid), 128'd0);
        start_op(64'd3, 64'd5, 64'd7);
        wait_valid();
        out_phase(128'd15, 64'd7, 0, 0, 1'b0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            logic [SIZE-1:0] ra;
            logic [SIZE-1:0] rb;
            logic [SIZE-1:0] rm;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rm = {$urandom, $urandom};
            if (i % 7 == 3) rb = '0;
            if (i % 5 == 1) ra = '1;
            start_op(ra, rb, rm);
            wait_valid();
            out_phase(ref_product(ra, rb), rm, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
